barcode_seq: RTL and testbench
==============================

Name: barcode_seq

Overview:
- Upstream sequencer for the iCE40UP barcode-emulation current sink.
- Stores a short list of bar/space elements and plays it out with exact timing on BARCODEPWM, with repeats.
- Drives CURREN and BARCODEEN so the current reference is warmed up before the pad is enabled, and everything is released when playback ends or is aborted.
- Its three drive outputs connect directly to the same-named inputs of the barcode driver primitive.

Parameters:
- DEPTH, 16, number of element slots in the pattern buffer (power of two, 2..64).
- WIDTH_W, 12, width of the per-element duration field, in ticks.
- PRESCALE_W, 8, width of the tick prescaler.
- WARMUP, 64, clock cycles CURREN is held high before BARCODEEN rises (1..1023).

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- WR_EN  in  1  write one element into the buffer.
- WR_DATA  in  WIDTH_W+1  bit[WIDTH_W] is the level (1 = bar, LED on); bits[WIDTH_W-1:0] are the duration in ticks.
- CLEAR  in  1  empties the buffer; honoured only in IDLE.
- WR_FULL  out  1  buffer holds DEPTH elements.
- START  in  1  begins playback; one-cycle pulse.
- ABORT  in  1  stops immediately; has priority over all other inputs.
- PRESCALE  in  PRESCALE_W  one tick = PRESCALE+1 clocks; sampled at START.
- REPEAT  in  4  extra passes after the first (0 = play once); sampled at START.
- BUSY  out  1  high in any state other than IDLE.
- DONE  out  1  one-cycle pulse on normal completion.
- CURREN  out  1  current-reference enable to the driver.
- BARCODEEN  out  1  pad enable to the driver.
- BARCODEPWM  out  1  modulation to the driver.

Behaviour:
- Reset:
  - State goes to IDLE; buffer count = 0.
  - All outputs are 0, including WR_FULL, BUSY and DONE.
  - Buffer contents may be left uninitialised.
- All outputs are registered; no combinational path from any input to any output.
- Writes:
  - Accepted only in IDLE with count < DEPTH.
  - An accepted write stores to slot[count], and count increments.
  - Writes while BUSY or while full are dropped silently, with no state change.
  - WR_FULL = (count == DEPTH), updated the cycle after the write.
  - CLEAR in IDLE sets count = 0; if CLEAR and WR_EN occur together, CLEAR wins.
- States:
  - IDLE: CURREN = BARCODEEN = BARCODEPWM = 0. START with count > 0 latches PRESCALE and REPEAT and moves to WARMUP. START with count == 0 is ignored.
  - WARMUP: CURREN = 1. A cycle counter runs for WARMUP cycles, then the state moves to PLAY with idx = 0 and the slot[0] duration loaded.
  - PLAY:
    - CURREN = BARCODEEN = 1 and BARCODEPWM = level of slot[idx].
    - Each element lasts max(duration, 1) × (PRESCALE+1) cycles; duration 0 is treated as 1.
    - At the end of an element, idx increments and the next element loads with no gap cycle.
    - After idx = count-1: if passes remaining > 0, decrement and set idx = 0; otherwise go to FINISH.
  - FINISH: lasts one cycle. BARCODEPWM = BARCODEEN = CURREN = 0 and DONE = 1, then the state returns to IDLE.
- Timing:
  - START sampled in cycle n gives CURREN = 1 in cycle n+1.
  - BARCODEEN rises, and BARCODEPWM shows element 0, in cycle n+1+WARMUP.
  - Total PLAY length = (REPEAT+1) × Σ max(d_i, 1) × (PRESCALE+1) cycles.
- BARCODEPWM changes only at element boundaries. Consecutive elements with equal level produce no glitch.
- BARCODEEN is never high while CURREN is low.
- ABORT in any non-IDLE state: the next cycle is IDLE with all drive outputs at 0 and no DONE. The buffer is retained.
- START while BUSY is ignored.
- RST asserted mid-playback: outputs go to 0 immediately (asynchronously) and the buffer count clears.

Test Plan:
- Reset + idle: assert RST during PLAY → CURREN, BARCODEEN, BARCODEPWM, BUSY go to 0 within the same cycle; count = 0 and START is then ignored.
- Basic playback:
  - Setup: WARMUP = 64, PRESCALE = 3, REPEAT = 0; write {1,5}, {0,2}, {1,1}; pulse START at cycle n.
  - Required: CURREN high at n+1; BARCODEEN high at n+65.
  - Required: BARCODEPWM high 20 cycles, low 8, high 4, then FINISH with DONE = 1 for one cycle.
- Repeat and zero width: PRESCALE = 0, REPEAT = 2, elements {1,0}, {0,3} → the pattern H1 L3 appears 3 times (12 cycles of PLAY); exactly one DONE pulse.
- Buffer full / write gating: write 17 elements with DEPTH = 16 → WR_FULL after the 16th and the 17th is dropped. Writes during BUSY leave count = 16. CLEAR + WR_EN together → count = 0.
- Abort: ABORT during WARMUP and again mid-element in PLAY → IDLE the next cycle, outputs 0, DONE never asserted; a subsequent START replays the retained buffer correctly.
- Enable ordering: random patterns, PRESCALE, REPEAT and ABORT timing → assertion that BARCODEEN implies CURREN holds every cycle, and BARCODEPWM = 0 whenever BARCODEEN = 0.

Source files
------------

// File: rtl/barcode_seq.sv
// Barcode-emulation sequencer: buffers bar/space elements and plays them out on
// BARCODEPWM with exact tick timing, sequencing CURREN/BARCODEEN around playback.
module barcode_seq #(
   parameter int unsigned DEPTH      = 16,
   parameter int unsigned WIDTH_W    = 12,
   parameter int unsigned PRESCALE_W = 8,
   parameter int unsigned WARMUP     = 64
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WR_EN,
   input  logic [WIDTH_W:0]      WR_DATA,
   input  logic                  CLEAR,
   output logic                  WR_FULL,
   input  logic                  START,
   input  logic                  ABORT,
   input  logic [PRESCALE_W-1:0] PRESCALE,
   input  logic [3:0]            REPEAT,
   output logic                  BUSY,
   output logic                  DONE,
   output logic                  CURREN,
   output logic                  BARCODEEN,
   output logic                  BARCODEPWM
);

   localparam int unsigned IW = $clog2(DEPTH);
   localparam int unsigned CW = IW + 1;
   localparam int unsigned WW = 10;

   typedef enum logic [1:0] {StIdle, StWarmup, StPlay, StFinish} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [IW-1:0]         idx_q, idx_d, nxt_idx;
   logic [WIDTH_W-1:0]    rem_q, rem_d;
   logic [PRESCALE_W-1:0] pre_q, pre_d, presc_q, presc_d;
   logic [3:0]            rep_q, rep_d;
   logic [WW-1:0]         warm_q, warm_d;
   logic                  lvl_q, lvl_d;
   logic                  wr_ok, load;
   logic [WIDTH_W:0]      nxt_elem;
   logic                  curren_d, baren_d, pwm_d, done_d, busy_d, full_d;

   logic [WIDTH_W:0]      mem [DEPTH];

   // Next-state logic: buffer writes, warm-up countdown and element timing.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      pre_d   = pre_q;
      presc_d = presc_q;
      rep_d   = rep_q;
      warm_d  = warm_q;
      lvl_d   = lvl_q;
      wr_ok   = 1'b0;
      load    = 1'b0;
      nxt_idx = '0;
      if (ABORT) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (CLEAR) begin
                  count_d = '0;
               end else if (WR_EN && (count_q < CW'(DEPTH))) begin
                  wr_ok   = 1'b1;
                  count_d = count_q + CW'(1);
               end
               if (START && (count_q != '0)) begin
                  presc_d = PRESCALE;
                  rep_d   = REPEAT;
                  warm_d  = WW'(WARMUP - 1);
                  state_d = StWarmup;
               end
            end
            StWarmup: begin
               if (warm_q == '0) begin
                  state_d = StPlay;
                  load    = 1'b1;
               end else begin
                  warm_d = warm_q - WW'(1);
               end
            end
            StPlay: begin
               if (pre_q != '0) begin
                  pre_d = pre_q - PRESCALE_W'(1);
               end else if (rem_q != '0) begin
                  rem_d = rem_q - WIDTH_W'(1);
                  pre_d = presc_q;
               end else if ({1'b0, idx_q} != (count_q - CW'(1))) begin
                  load    = 1'b1;
                  nxt_idx = idx_q + IW'(1);
               end else if (rep_q != '0) begin
                  rep_d = rep_q - 4'd1;
                  load  = 1'b1;
               end else begin
                  state_d = StFinish;
               end
            end
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
         endcase
      end
      nxt_elem = mem[nxt_idx];
      // Element load: duration 0 plays as one tick, so remaining ticks = max(d,1)-1.
      if (load) begin
         idx_d = nxt_idx;
         rem_d = (nxt_elem[WIDTH_W-1:0] == '0) ? '0 : nxt_elem[WIDTH_W-1:0] - WIDTH_W'(1);
         pre_d = presc_q;
         lvl_d = nxt_elem[WIDTH_W];
      end
      // Outputs decoded from the next state so they are registered yet cycle-exact.
      curren_d = (state_d == StWarmup) || (state_d == StPlay);
      baren_d  = (state_d == StPlay);
      pwm_d    = (state_d == StPlay) && lvl_d;
      done_d   = (state_d == StFinish);
      busy_d   = (state_d != StIdle);
      full_d   = (count_d == CW'(DEPTH));
   end

   // State and registered outputs; reset drops all drive outputs asynchronously.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q    <= StIdle;
         count_q    <= '0;
         idx_q      <= '0;
         rem_q      <= '0;
         pre_q      <= '0;
         presc_q    <= '0;
         rep_q      <= '0;
         warm_q     <= '0;
         lvl_q      <= 1'b0;
         CURREN     <= 1'b0;
         BARCODEEN  <= 1'b0;
         BARCODEPWM <= 1'b0;
         DONE       <= 1'b0;
         BUSY       <= 1'b0;
         WR_FULL    <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         idx_q      <= idx_d;
         rem_q      <= rem_d;
         pre_q      <= pre_d;
         presc_q    <= presc_d;
         rep_q      <= rep_d;
         warm_q     <= warm_d;
         lvl_q      <= lvl_d;
         CURREN     <= curren_d;
         BARCODEEN  <= baren_d;
         BARCODEPWM <= pwm_d;
         DONE       <= done_d;
         BUSY       <= busy_d;
         WR_FULL    <= full_d;
      end
   end

   // Pattern buffer; contents need no reset since count gates every read.
   always_ff @(posedge CLK) begin
      if (wr_ok) begin
         mem[count_q[IW-1:0]] <= WR_DATA;
      end
   end

endmodule

// File: tb/tb_barcode_seq.sv
// Directed bench for barcode_seq: timing, repeats, buffer gating, abort and reset.
module tb_barcode_seq;

   localparam int unsigned DEPTH      = 16;
   localparam int unsigned WIDTH_W    = 12;
   localparam int unsigned PRESCALE_W = 8;
   localparam int unsigned WARMUP     = 64;

   logic                  CLK = 1'b0;
   logic                  RST = 1'b1;
   logic                  WR_EN = 1'b0;
   logic [WIDTH_W:0]      WR_DATA = '0;
   logic                  CLEAR = 1'b0;
   logic                  START = 1'b0;
   logic                  ABORT = 1'b0;
   logic [PRESCALE_W-1:0] PRESCALE = '0;
   logic [3:0]            REPEAT = '0;
   logic                  WR_FULL, BUSY, DONE, CURREN, BARCODEEN, BARCODEPWM;

   int   n_checks = 0;
   int   n_fail = 0;
   int   done_cnt = 0;
   int   viol = 0;
   logic cap[$];
   logic expq[$];
   logic m_lvl[$];
   int   m_dur[$];

   barcode_seq #(
      .DEPTH      (DEPTH),
      .WIDTH_W    (WIDTH_W),
      .PRESCALE_W (PRESCALE_W),
      .WARMUP     (WARMUP)
   ) dut (
      .CLK        (CLK),
      .RST        (RST),
      .WR_EN      (WR_EN),
      .WR_DATA    (WR_DATA),
      .CLEAR      (CLEAR),
      .WR_FULL    (WR_FULL),
      .START      (START),
      .ABORT      (ABORT),
      .PRESCALE   (PRESCALE),
      .REPEAT     (REPEAT),
      .BUSY       (BUSY),
      .DONE       (DONE),
      .CURREN     (CURREN),
      .BARCODEEN  (BARCODEEN),
      .BARCODEPWM (BARCODEPWM)
   );

   always #5 CLK = ~CLK;

   // Every-cycle monitor: DONE pulses and enable ordering.
   always @(negedge CLK) begin
      if (DONE) done_cnt++;
      if (BARCODEEN && !CURREN) viol++;
      if (!BARCODEEN && BARCODEPWM) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic lvl, input int dur);
      WR_DATA = {lvl, dur[WIDTH_W-1:0]};
      WR_EN   = 1'b1;
      tick();
      WR_EN   = 1'b0;
   endtask

   task automatic wr_m(input logic lvl, input int dur);
      wr(lvl, dur);
      m_lvl.push_back(lvl);
      m_dur.push_back(dur);
   endtask

   task automatic clear_buf();
      CLEAR = 1'b1;
      tick();
      CLEAR = 1'b0;
      m_lvl.delete();
      m_dur.delete();
   endtask

   // Expected BARCODEPWM per PLAY cycle from the element list.
   task automatic build_exp(input int p, input int r);
      expq.delete();
      for (int pass = 0; pass <= r; pass++) begin
         for (int i = 0; i < m_lvl.size(); i++) begin
            int d;
            d = (m_dur[i] == 0) ? 1 : m_dur[i];
            repeat (d * (p + 1)) expq.push_back(m_lvl[i]);
         end
      end
   endtask

   task automatic start_play(input int p, input int r);
      PRESCALE = p[PRESCALE_W-1:0];
      REPEAT   = r[3:0];
      START    = 1'b1;
      tick();
      START    = 1'b0;
   endtask

   // lat0 = cycles since START's cycle at entry; BARCODEEN must rise at WARMUP+1.
   task automatic wait_en(input string tag, input int lat0);
      int lat;
      lat = lat0;
      while (!BARCODEEN && lat < int'(WARMUP) + 20) begin
         tick();
         lat++;
      end
      check({tag, "_lat"}, lat, WARMUP + 1);
   endtask

   task automatic capture(input string tag);
      int guard;
      guard = 0;
      cap.delete();
      while (BARCODEEN === 1'b1 && guard < 5000) begin
         cap.push_back(BARCODEPWM);
         tick();
         guard++;
      end
      check({tag, "_bound"}, 32'(guard < 5000), 1);
   endtask

   task automatic finish_check(input string tag, input int d0);
      int mism;
      capture(tag);
      check({tag, "_done"}, 32'(DONE), 1);
      check({tag, "_curoff"}, 32'(CURREN), 0);
      tick();
      check({tag, "_idle"}, 32'({BUSY, DONE}), 0);
      check({tag, "_len"}, cap.size(), expq.size());
      mism = 0;
      for (int i = 0; i < cap.size() && i < expq.size(); i++)
         if (cap[i] !== expq[i]) mism++;
      check({tag, "_bits"}, mism, 0);
      check({tag, "_ndone"}, done_cnt - d0, 1);
   endtask

   task automatic play_check(input string tag, input int p, input int r);
      int d0;
      build_exp(p, r);
      d0 = done_cnt;
      start_play(p, r);
      wait_en(tag, 1);
      finish_check(tag, d0);
   endtask

   initial begin
      int d0;
      int runs[$];
      int rl;

      // Reset state
      tick();
      check("rst_outs", 32'({WR_FULL, BUSY, DONE, CURREN, BARCODEEN, BARCODEPWM}), 0);
      RST = 1'b0;
      tick();

      // Basic playback: PRESCALE 3 -> runs of 20 high, 8 low, 4 high
      wr_m(1'b1, 5);
      wr_m(1'b0, 2);
      wr_m(1'b1, 1);
      check("basic_notfull", 32'(WR_FULL), 0);
      build_exp(3, 0);
      d0 = done_cnt;
      start_play(3, 0);
      check("basic_cur_n1", 32'({BUSY, CURREN, BARCODEEN}), 3'b110);
      repeat (63) tick();
      check("basic_n64", 32'({CURREN, BARCODEEN}), 2'b10);
      tick();
      check("basic_n65", 32'({CURREN, BARCODEEN, BARCODEPWM}), 3'b111);
      finish_check("basic", d0);
      rl = 1;
      for (int i = 1; i <= cap.size(); i++) begin
         if (i == cap.size() || cap[i] !== cap[i-1]) begin
            runs.push_back(rl);
            rl = 1;
         end else begin
            rl++;
         end
      end
      check("basic_nruns", runs.size(), 3);
      if (runs.size() == 3) begin
         check("basic_run0", runs[0], 20);
         check("basic_run1", runs[1], 8);
         check("basic_run2", runs[2], 4);
      end

      // Repeat and zero-width element: H1 L3 three times
      clear_buf();
      wr_m(1'b1, 0);
      wr_m(1'b0, 3);
      play_check("rep", 0, 2);
      check("rep_len12", cap.size(), 12);

      // Buffer full and write gating
      clear_buf();
      for (int i = 0; i < 16; i++) begin
         wr_m(1'(i % 2), i % 3);
         if (i == 14) check("full_at15", 32'(WR_FULL), 0);
      end
      check("full_at16", 32'(WR_FULL), 1);
      wr(1'b1, 7);
      check("full_17th", 32'(WR_FULL), 1);
      build_exp(0, 0);
      d0 = done_cnt;
      start_play(0, 0);
      wr(1'b1, 9);
      wait_en("full", 2);
      finish_check("full", d0);
      check("full_after_busy", 32'(WR_FULL), 1);
      CLEAR   = 1'b1;
      WR_EN   = 1'b1;
      WR_DATA = {1'b1, 12'd4};
      tick();
      CLEAR = 1'b0;
      WR_EN = 1'b0;
      m_lvl.delete();
      m_dur.delete();
      check("clr_full", 32'(WR_FULL), 0);
      start_play(0, 0);
      check("clr_start_ign", 32'({BUSY, CURREN}), 0);
      wr_m(1'b1, 2);
      play_check("clr_one", 0, 0);

      // Abort in WARMUP and mid-element in PLAY, then replay
      clear_buf();
      wr_m(1'b1, 5);
      wr_m(1'b0, 2);
      wr_m(1'b1, 1);
      d0 = done_cnt;
      start_play(3, 0);
      repeat (10) tick();
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      check("abw_outs", 32'({BUSY, DONE, CURREN, BARCODEEN, BARCODEPWM}), 0);
      start_play(3, 0);
      wait_en("abp", 1);
      repeat (7) tick();
      check("abp_mid", 32'(BARCODEPWM), 1);
      ABORT = 1'b1;
      tick();
      ABORT = 1'b0;
      check("abp_outs", 32'({BUSY, DONE, CURREN, BARCODEEN, BARCODEPWM}), 0);
      tick();
      check("ab_nodone", done_cnt - d0, 0);
      play_check("ab_replay", 3, 0);

      // Asynchronous reset during PLAY
      start_play(1, 1);
      wait_en("rstp", 1);
      repeat (5) tick();
      #2 RST = 1'b1;
      #1 check("rstp_async", 32'({BUSY, CURREN, BARCODEEN, BARCODEPWM}), 0);
      #1 RST = 1'b0;
      m_lvl.delete();
      m_dur.delete();
      tick();
      start_play(0, 0);
      check("rstp_start_ign", 32'({BUSY, CURREN}), 0);

      // Random patterns with optional abort; ordering monitored every cycle
      for (int it = 0; it < 8; it++) begin
         int n, p, r;
         n = int'($urandom_range(1, 4));
         p = int'($urandom_range(0, 2));
         r = int'($urandom_range(0, 2));
         clear_buf();
         for (int k = 0; k < n; k++) wr_m(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
         if ($urandom_range(0, 1) == 1) begin
            start_play(p, r);
            repeat ($urandom_range(1, 90)) tick();
            ABORT = 1'b1;
            tick();
            ABORT = 1'b0;
            check("rnd_abort", 32'({BUSY, CURREN, BARCODEEN}), 0);
         end else begin
            play_check("rnd", p, r);
         end
      end
      check("order_viol", viol, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
